// File: rtl/scale_mux_pkg.sv
// scale_mux shared constants.
// Width limits and default for the select primitive.
package scale_mux_pkg;

  localparam int unsigned SIZE_DEF = 1;
  localparam int unsigned SIZE_MIN = 1;
  localparam int unsigned SIZE_MAX = 1024;

endpackage

// File: rtl/scale_mux_if.sv
// scale_mux operand/result bundle.
// master drives operands, slave returns the registered word.
interface scale_mux_if
  import scale_mux_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF
);

  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            sel;
  logic            en;
  logic [SIZE-1:0] out;
  logic            out_valid;

  modport master (
    output a, b, sel, en,
    input  out, out_valid
  );

  modport slave (
    input  a, b, sel, en,
    output out, out_valid
  );

endinterface

// File: rtl/scale_mux_bit.sv
// scale_mux single-bit select cell.
// Unknown select merges operands that agree and are known.
module scale_mux_bit (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  // a^b is unknown if either operand is, so only
  // known, equal operands survive an unknown select
  always_comb begin
    y = a;
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = ((a ^ b) === 1'b0) ? a : 1'bx;
    endcase
  end

endmodule

// File: rtl/scale_mux.sv
// scale_mux: SIZE-bit 2:1 mux with registered output.
// out_valid marks a word loaded since the last reset.
module scale_mux
  import scale_mux_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  scale_mux_if.slave   bus
);

  logic [SIZE-1:0] nxt;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    scale_mux_bit u_bit (
      .a   (bus.a[i]),
      .b   (bus.b[i]),
      .sel (bus.sel),
      .y   (nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.en) begin
      bus.out       <= nxt;
      bus.out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scale_mux.sv
// scale_mux directed bench at SIZE 1, 4, 5 and 6.
// x-select checks are exact on 4-state sims, masked on 2-state.
module tb_scale_mux;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic four_state;
  logic probe;

  always #5 clk = ~clk;

  scale_mux_if              i1 ();
  scale_mux_if #(.SIZE(4))  i4 ();
  scale_mux_if #(.SIZE(5))  i5 ();
  scale_mux_if #(.SIZE(6))  i6 ();

  scale_mux u1 (
    .clk (clk), .rst (rst), .bus (i1.slave)
  );

  scale_mux #(.SIZE(4)) u4 (
    .clk (clk), .rst (rst), .bus (i4.slave)
  );

  scale_mux #(5) u5 (
    .clk (clk), .rst (rst), .bus (i5.slave)
  );

  scale_mux u6 (
    .clk (clk), .rst (rst), .bus (i6.slave)
  );
  defparam u6.SIZE = 6;

  task automatic check(
    input string      tag,
    input logic [5:0] got,
    input logic [5:0] exp,
    input logic [5:0] xm
  );
    logic [5:0] e;
    logic       ok;
    checks++;
    for (int i = 0; i < 6; i++)
      e[i] = xm[i] ? 1'bx : exp[i];
    if (four_state)
      ok = (got === e);
    else
      ok = ((got & ~xm) === (exp & ~xm));
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       s,
    input logic       e,
    input logic [5:0] a1, b1,
    input logic [5:0] a4, b4,
    input logic [5:0] a5, b5,
    input logic [5:0] a6, b6
  );
    i1.sel = s; i4.sel = s;
    i5.sel = s; i6.sel = s;
    i1.en  = e; i4.en  = e;
    i5.en  = e; i6.en  = e;
    i1.a = a1[0:0]; i1.b = b1[0:0];
    i4.a = a4[3:0]; i4.b = b4[3:0];
    i5.a = a5[4:0]; i5.b = b5[4:0];
    i6.a = a6[5:0]; i6.b = b6[5:0];
  endtask

  task automatic expect_out(
    input string      tag,
    input logic [5:0] e1, x1,
    input logic [5:0] e4, x4,
    input logic [5:0] e5, x5,
    input logic [5:0] e6, x6
  );
    check({tag, "/o1"}, 6'(i1.out), e1, x1);
    check({tag, "/o4"}, 6'(i4.out), e4, x4);
    check({tag, "/o5"}, 6'(i5.out), e5, x5);
    check({tag, "/o6"}, 6'(i6.out), e6, x6);
  endtask

  task automatic expect_valid(
    input string tag,
    input logic  v
  );
    check({tag, "/v1"}, 6'(i1.out_valid), 6'(v), '0);
    check({tag, "/v4"}, 6'(i4.out_valid), 6'(v), '0);
    check({tag, "/v5"}, 6'(i5.out_valid), 6'(v), '0);
    check({tag, "/v6"}, 6'(i6.out_valid), 6'(v), '0);
  endtask

  initial begin
    probe = 1'bx;
    four_state = $isunknown(probe);

    rst = 1'b1;
    drive(1'b0, 1'b1, 6'h3f, 6'h3f, 6'h3f, 6'h3f,
          6'h3f, 6'h3f, 6'h3f, 6'h3f);
    tick();
    expect_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_valid("rst", 1'b0);

    rst = 1'b0;
    drive(1'b1, 1'b0, 6'b1, 6'b1, 6'b1111, 6'b1010,
          6'b11111, 6'b10101, 6'b111111, 6'b010101);
    tick();
    expect_out("hold0", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_valid("hold0", 1'b0);

    drive(1'b0, 1'b1, 6'b1, 6'b0, 6'b1100, 6'b0011,
          6'b11100, 6'b00011, 6'b111000, 6'b000111);
    tick();
    expect_out("sel0", 6'b1, 0, 6'b1100, 0,
               6'b11100, 0, 6'b111000, 0);
    expect_valid("sel0", 1'b1);

    drive(1'b1, 1'b0, 6'b1, 6'b0, 6'b1100, 6'b0011,
          6'b11100, 6'b00011, 6'b111000, 6'b000111);
    tick();
    expect_out("hold1", 6'b1, 0, 6'b1100, 0,
               6'b11100, 0, 6'b111000, 0);

    drive(1'b1, 1'b1, 6'b1, 6'b0, 6'b1100, 6'b0011,
          6'b11100, 6'b00011, 6'b111000, 6'b000111);
    tick();
    expect_out("sel1", 6'b0, 0, 6'b0011, 0,
               6'b00011, 0, 6'b000111, 0);

    drive(1'bx, 1'b1, 6'b1, 6'b0, 6'b1100, 6'b0011,
          6'b11100, 6'b00011, 6'b111000, 6'b000111);
    tick();
    expect_out("selx_ne", 0, 6'b1, 0, 6'b1111,
               0, 6'b11111, 0, 6'b111111);

    drive(1'bx, 1'b1, 6'b0, 6'b0, 6'b1100, 6'b1100,
          6'b11100, 6'b11100, 6'b111000, 6'b111000);
    tick();
    expect_out("selx_eq", 6'b0, 0, 6'b1100, 0,
               6'b11100, 0, 6'b111000, 0);

    drive(1'bx, 1'b1, 6'b1, 6'b1, 6'b1011, 6'b1010,
          6'b11111, 6'b00111, 6'b111000, 6'b001100);
    tick();
    expect_out("selx_part", 6'b1, 0, 6'b1010, 6'b0001,
               6'b00111, 6'b11000, 6'b001000, 6'b110100);

    rst = 1'b1;
    drive(1'b0, 1'b1, 6'b1, 6'b0, 6'b1100, 6'b0011,
          6'b11100, 6'b00011, 6'b111000, 6'b000111);
    tick();
    expect_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_valid("rst_mid", 1'b0);

    rst = 1'b0;
    drive(1'b1, 1'b1, 6'b1, 6'b0, 6'b1100, 6'b0011,
          6'b11100, 6'b00011, 6'b111000, 6'b000111);
    tick();
    expect_out("reload", 6'b0, 0, 6'b0011, 0,
               6'b00011, 0, 6'b000111, 0);
    expect_valid("reload", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
